// File: rtl/spgd_update_ctrl.sv
// SPGD control-vector update sequencer: latches J+/J-, requests gain*dJ from the shared
// multiplier, applies +/-step to every channel and advances the perturbation LFSR.
// Optional feature macro: SPGD_STEP_LIMIT_EN clamps the step to [-STEP_MAX, STEP_MAX].
module spgd_update_ctrl #(
  parameter int          N_CH       = 8,
  parameter int          J_W        = 16,
  parameter int          U_W        = 14,
  parameter int          GAIN_SHIFT = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          STEP_MAX   = 1024
) (
  input  logic                  ADC_CLK,
  input  logic                  RST_N,
  input  logic                  JP_WRT,
  input  logic                  JM_WRT,
  input  logic                  U_WRT,
  input  logic signed [J_W-1:0] J_IN,
  input  logic signed [7:0]     GAIN,
  output logic                  MUL_REQ,
  output logic signed [J_W:0]   MUL_A,
  output logic signed [7:0]     MUL_B,
  input  logic                  MUL_ACK,
  input  logic signed [J_W+8:0] MUL_P,
  output logic                  U_WE,
  output logic [3:0]            U_ADDR,
  output logic signed [U_W-1:0] U_DATA,
  output logic [N_CH-1:0]       PERT_SIGN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  OVERRUN
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PW = J_W + 9;
  localparam int AW = ((U_W > PW) ? U_W : PW) + 2;
  localparam logic signed [AW-1:0] U_MAX = AW'((1 << (U_W - 1)) - 1);
  localparam logic signed [AW-1:0] U_MIN = ~U_MAX;

  if (N_CH < 1 || N_CH > 16 || LFSR_SEED == 16'h0000 || STEP_MAX < 1) begin : g_param_check
    $error("spgd_update_ctrl: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, MREQ, UPD, STEP, FIN} state_t;

  state_t                state;
  logic signed [J_W-1:0] jp;
  logic signed [J_W-1:0] jm;
  logic signed [J_W:0]   dj;
  logic signed [7:0]     gain;
  logic signed [PW-1:0]  step;
  logic signed [U_W-1:0] u_sh [N_CH];
  logic [15:0]           lfsr;
  logic [IW-1:0]         idx;

  logic signed [PW-1:0]  step_next;
  logic signed [AW-1:0]  cur;
  logic signed [AW-1:0]  delta;
  logic signed [AW-1:0]  sum;
  logic signed [U_W-1:0] u_new;

  assign MUL_A     = dj;
  assign MUL_B     = gain;
  assign PERT_SIGN = lfsr[N_CH-1:0];

`ifdef SPGD_STEP_LIMIT_EN
  localparam logic signed [PW-1:0] S_MAX = PW'(STEP_MAX);
  localparam logic signed [PW-1:0] S_MIN = -S_MAX;
`endif

  always_comb begin
    step_next = MUL_P >>> GAIN_SHIFT;
`ifdef SPGD_STEP_LIMIT_EN
    if (step_next > S_MAX)
      step_next = S_MAX;
    else if (step_next < S_MIN)
      step_next = S_MIN;
`endif
  end

  // Wide enough that negating the most negative step and the add cannot wrap before saturation
  always_comb begin
    cur   = AW'(u_sh[idx]);
    delta = PERT_SIGN[idx] ? AW'(step) : -AW'(step);
    sum   = cur + delta;
    if (sum > U_MAX)
      u_new = U_MAX[U_W-1:0];
    else if (sum < U_MIN)
      u_new = U_MIN[U_W-1:0];
    else
      u_new = sum[U_W-1:0];
  end

  always_ff @(posedge ADC_CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      jp      <= '0;
      jm      <= '0;
      dj      <= '0;
      gain    <= '0;
      step    <= '0;
      for (int i = 0; i < N_CH; i++) u_sh[i] <= '0;
      lfsr    <= LFSR_SEED;
      idx     <= '0;
      MUL_REQ <= 1'b0;
      U_WE    <= 1'b0;
      U_ADDR  <= '0;
      U_DATA  <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      if (JP_WRT) jp <= J_IN;
      if (JM_WRT) jm <= J_IN;
      // FIN is the DONE cycle, so a start request there also counts as an overrun
      if (U_WRT && state != IDLE) OVERRUN <= 1'b1;
      U_WE <= 1'b0;
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (U_WRT) begin
            dj      <= (J_W+1)'(jp) - (J_W+1)'(jm);
            gain    <= GAIN;
            BUSY    <= 1'b1;
            MUL_REQ <= 1'b1;
            state   <= MREQ;
          end
        end
        MREQ: begin
          if (MUL_ACK) begin
            step    <= step_next;
            MUL_REQ <= 1'b0;
            idx     <= '0;
            state   <= UPD;
          end
        end
        UPD: begin
          u_sh[idx] <= u_new;
          U_WE      <= 1'b1;
          U_ADDR    <= 4'(idx);
          U_DATA    <= u_new;
          if (idx == IW'(N_CH - 1))
            state <= STEP;
          else
            idx <= idx + 1'b1;
        end
        STEP: begin
          lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= FIN;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spgd_update_ctrl.sv
// Self-checking bench for spgd_update_ctrl: directed scenarios plus randomized sequences,
// checked against an arithmetic per-channel model of the update rule.
module tb_spgd_update_ctrl;

  localparam int          N_CH       = 8;
  localparam int          J_W        = 16;
  localparam int          U_W        = 14;
  localparam int          GAIN_SHIFT = 4;
  localparam logic [15:0] SEED       = 16'hACE1;

  logic                  ADC_CLK = 1'b0;
  logic                  RST_N   = 1'b0;
  logic                  JP_WRT  = 1'b0;
  logic                  JM_WRT  = 1'b0;
  logic                  U_WRT   = 1'b0;
  logic signed [J_W-1:0] J_IN    = '0;
  logic signed [7:0]     GAIN    = '0;
  logic                  MUL_REQ;
  logic signed [J_W:0]   MUL_A;
  logic signed [7:0]     MUL_B;
  logic                  MUL_ACK = 1'b0;
  logic signed [J_W+8:0] MUL_P   = '0;
  logic                  U_WE;
  logic [3:0]            U_ADDR;
  logic signed [U_W-1:0] U_DATA;
  logic [N_CH-1:0]       PERT_SIGN;
  logic                  BUSY;
  logic                  DONE;
  logic                  OVERRUN;

  spgd_update_ctrl dut (
    .ADC_CLK(ADC_CLK), .RST_N(RST_N), .JP_WRT(JP_WRT), .JM_WRT(JM_WRT), .U_WRT(U_WRT),
    .J_IN(J_IN), .GAIN(GAIN), .MUL_REQ(MUL_REQ), .MUL_A(MUL_A), .MUL_B(MUL_B),
    .MUL_ACK(MUL_ACK), .MUL_P(MUL_P), .U_WE(U_WE), .U_ADDR(U_ADDR), .U_DATA(U_DATA),
    .PERT_SIGN(PERT_SIGN), .BUSY(BUSY), .DONE(DONE), .OVERRUN(OVERRUN)
  );

  always #5 ADC_CLK = ~ADC_CLK;

  int checks = 0;
  int failures = 0;
  int we_count = 0;

  always @(negedge ADC_CLK) if (U_WE === 1'b1) we_count++;

  // Reference model state
  int          jp_m, jm_m;
  int          u_m [N_CH];
  logic [15:0] lfsr_m;
  bit          ovr_m;

  function automatic int sat_u(input longint v);
    longint hi, lo;
    hi = (64'sd1 <<< (U_W - 1)) - 1;
    lo = -(64'sd1 <<< (U_W - 1));
    if (v > hi) return int'(hi);
    if (v < lo) return int'(lo);
    return int'(v);
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    int fb;
    fb = $countones(v & 16'hB400) % 2;
    return {v[14:0], fb[0]};
  endfunction

  function automatic longint model_step(input longint prod);
    longint s;
    s = prod >>> GAIN_SHIFT;
`ifdef SPGD_STEP_LIMIT_EN
    if (s > 1024) s = 1024;
    else if (s < -1024) s = -1024;
`endif
    return s;
  endfunction

  task automatic modelReset;
    jp_m = 0;
    jm_m = 0;
    for (int i = 0; i < N_CH; i++) u_m[i] = 0;
    lfsr_m = SEED;
    ovr_m = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge ADC_CLK);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_mul_req"}, MUL_REQ, 0);
    checkOutput({tag, "_mul_a"}, MUL_A, 0);
    checkOutput({tag, "_mul_b"}, MUL_B, 0);
    checkOutput({tag, "_u_we"}, U_WE, 0);
    checkOutput({tag, "_u_addr"}, U_ADDR, 0);
    checkOutput({tag, "_u_data"}, U_DATA, 0);
    checkOutput({tag, "_busy"}, BUSY, 0);
    checkOutput({tag, "_done"}, DONE, 0);
    checkOutput({tag, "_overrun"}, OVERRUN, 0);
    checkOutput({tag, "_pert"}, PERT_SIGN, SEED[N_CH-1:0]);
  endtask

  task automatic applyStimulus(input bit is_jp, input int val);
    J_IN = J_W'(val);
    if (is_jp) JP_WRT = 1'b1; else JM_WRT = 1'b1;
    tick;
    JP_WRT = 1'b0;
    JM_WRT = 1'b0;
    J_IN = J_W'($urandom);
    if (is_jp) jp_m = val; else jm_m = val;
  endtask

  // One full update sequence; the bench acts as the shared multiplier.
  task automatic runSequence(input int g, input int ack_delay, input int extra_at,
                             input bit jp_req, input int jp_val, input int abort_ch,
                             input bit uwrt_at_done);
    int     dj;
    longint step;
    int     base;
    dj = jp_m - jm_m;
    step = model_step(longint'(dj) * longint'(g));
    base = we_count;
    GAIN = 8'(g);
    U_WRT = 1'b1;
    tick;
    U_WRT = 1'b0;
    GAIN = 8'($urandom);
    for (int c = 0; c < ack_delay; c++) begin
      if (jp_req && c == 0) begin
        JP_WRT = 1'b1;
        J_IN = J_W'(jp_val);
      end
      @(negedge ADC_CLK);
      checkOutput("wait_mul_req", MUL_REQ, 1);
      checkOutput("wait_mul_a", MUL_A, dj);
      checkOutput("wait_mul_b", MUL_B, g);
      checkOutput("wait_u_we", U_WE, 0);
      checkOutput("wait_busy", BUSY, 1);
      tick;
      if (jp_req && c == 0) begin
        JP_WRT = 1'b0;
        jp_m = jp_val;
      end
    end
    MUL_ACK = 1'b1;
    MUL_P = (J_W+9)'(longint'(dj) * longint'(g));
    @(negedge ADC_CLK);
    checkOutput("ack_mul_req", MUL_REQ, 1);
    checkOutput("ack_mul_a", MUL_A, dj);
    checkOutput("ack_mul_b", MUL_B, g);
    tick;
    MUL_ACK = 1'b0;
    MUL_P = (J_W+9)'($urandom);
    @(negedge ADC_CLK);
    checkOutput("req_drop", MUL_REQ, 0);
    checkOutput("pre_u_we", U_WE, 0);
    tick;
    for (int i = 0; i < N_CH; i++) begin
      u_m[i] = sat_u(longint'(u_m[i]) + (lfsr_m[i] ? step : -step));
      @(negedge ADC_CLK);
      checkOutput($sformatf("u_we%0d", i), U_WE, 1);
      checkOutput($sformatf("u_addr%0d", i), U_ADDR, i);
      checkOutput($sformatf("u_data%0d", i), U_DATA, u_m[i]);
      checkOutput($sformatf("pert_hold%0d", i), PERT_SIGN, lfsr_m[N_CH-1:0]);
      checkOutput($sformatf("overrun%0d", i), OVERRUN, ovr_m);
      if (i == extra_at) begin
        U_WRT = 1'b1;
        ovr_m = 1'b1;
      end
      if (i + 1 == abort_ch) RST_N = 1'b0;
      tick;
      U_WRT = 1'b0;
      if (i + 1 == abort_ch) begin
        RST_N = 1'b1;
        modelReset();
        @(negedge ADC_CLK);
        checkResetState("abort");
        tick;
        for (int k = 0; k < 3; k++) begin
          @(negedge ADC_CLK);
          checkOutput("abort_no_we", U_WE, 0);
          checkOutput("abort_no_busy", BUSY, 0);
          tick;
        end
        checkOutput("abort_we_count", we_count - base, abort_ch);
        return;
      end
    end
    lfsr_m = lfsr_adv(lfsr_m);
    @(negedge ADC_CLK);
    checkOutput("end_u_we", U_WE, 0);
    checkOutput("done", DONE, 1);
    checkOutput("busy_end", BUSY, 0);
    checkOutput("pert_next", PERT_SIGN, lfsr_m[N_CH-1:0]);
    if (uwrt_at_done) begin
      U_WRT = 1'b1;
      ovr_m = 1'b1;
    end
    tick;
    U_WRT = 1'b0;
    @(negedge ADC_CLK);
    checkOutput("done_one_cycle", DONE, 0);
    checkOutput("idle_busy", BUSY, 0);
    checkOutput("idle_mul_req", MUL_REQ, 0);
    checkOutput("idle_overrun", OVERRUN, ovr_m);
    tick;
    checkOutput("we_count", we_count - base, N_CH);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int jv, mv, gv, dv;
    modelReset();
    RST_N = 1'b0;
    tick;
    tick;
    RST_N = 1'b1;
    @(negedge ADC_CLK);
    checkResetState("reset");
    tick;

    // Stray ACK while idle must not start anything
    MUL_ACK = 1'b1;
    tick;
    MUL_ACK = 1'b0;
    @(negedge ADC_CLK);
    checkOutput("stray_ack_busy", BUSY, 0);
    checkOutput("stray_ack_we", U_WE, 0);
    tick;

    $display("[TB] basic update dJ=60, ACK after 1 cycle");
    applyStimulus(1'b1, 100);
    applyStimulus(1'b0, 40);
    runSequence(16, 1, -1, 1'b0, 0, -1, 1'b0);

    $display("[TB] ACK delayed 5 cycles");
    runSequence(16, 5, -1, 1'b0, 0, -1, 1'b0);

    $display("[TB] J+ rewritten while multiplier pending");
    runSequence(16, 3, -1, 1'b1, 500, -1, 1'b0);
    runSequence(16, 0, -1, 1'b0, 0, -1, 1'b0);

    $display("[TB] extreme metrics, saturation");
    applyStimulus(1'b1, 32767);
    applyStimulus(1'b0, -32768);
    runSequence(16, 2, -1, 1'b0, 0, -1, 1'b0);

    $display("[TB] U_WRT during UPD");
    runSequence(16, 1, 2, 1'b0, 0, -1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge ADC_CLK);
      checkOutput("overrun_sticky", OVERRUN, 1);
      checkOutput("overrun_no_seq", MUL_REQ, 0);
      tick;
    end

    $display("[TB] reset at channel 3, then fresh run");
    applyStimulus(1'b1, 100);
    applyStimulus(1'b0, 40);
    runSequence(16, 1, -1, 1'b0, 0, 3, 1'b0);
    applyStimulus(1'b1, 100);
    applyStimulus(1'b0, 40);
    runSequence(16, 1, -1, 1'b0, 0, -1, 1'b0);

    $display("[TB] randomized sequences");
    for (int r = 0; r < 8; r++) begin
      jv = int'($signed(16'($urandom)));
      mv = int'($signed(16'($urandom)));
      gv = int'($signed(8'($urandom)));
      dv = int'($urandom_range(0, 4));
      applyStimulus(1'b1, jv);
      applyStimulus(1'b0, mv);
      runSequence(gv, dv, -1, 1'b0, 0, -1, 1'b0);
    end

    $display("[TB] U_WRT coincident with DONE");
    runSequence(int'($signed(8'($urandom))), 1, -1, 1'b0, 0, -1, 1'b1);
    @(negedge ADC_CLK);
    checkOutput("done_uwrt_no_seq", MUL_REQ, 0);
    checkOutput("done_uwrt_overrun", OVERRUN, 1);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spgd_update_ctrl.md
Name: spgd_update_ctrl

Overview:
Sequences the SPGD control-vector update after each measurement cycle. It captures the J+ and J- metric samples on the measurement FSM's write strobes and computes dJ = J+ - J-. It obtains the gain-scaled step from the shared signed multiplier through a req/ack handshake, then walks all actuator channels, applying +step or -step according to each channel's perturbation sign. It writes the saturated results to the DAC register file and advances the LFSR that supplies the next perturbation pattern.

Parameters:
N_CH, 8, number of actuator channels (1..16)
J_W, 16, signed metric width
U_W, 14, signed control-word width per channel
GAIN_SHIFT, 4, arithmetic right shift applied to the product
LFSR_SEED, 16'hACE1, LFSR value loaded at reset (must be nonzero)
STEP_MAX, 1024, step magnitude limit (used only with the optional feature)

Ports:
ADC_CLK  in  1  system clock; all logic on the rising edge
RST_N  in  1  synchronous reset, active-low
JP_WRT  in  1  one-cycle strobe: latch J_IN as J+
JM_WRT  in  1  one-cycle strobe: latch J_IN as J-
U_WRT  in  1  one-cycle strobe: start an update sequence
J_IN  in  J_W  signed metric sample
GAIN  in  8  signed gain, sampled when U_WRT is accepted
MUL_REQ  out  1  multiplier request
MUL_A  out  J_W+1  signed operand (dJ)
MUL_B  out  8  signed operand (gain)
MUL_ACK  in  1  multiplier done; MUL_P valid in the same cycle
MUL_P  in  J_W+9  signed product
U_WE  out  1  register-file write enable
U_ADDR  out  4  channel index
U_DATA  out  U_W  signed new control word
PERT_SIGN  out  N_CH  current perturbation signs (1 = +, 0 = -) = lfsr[N_CH-1:0]
BUSY  out  1  high from U_WRT acceptance until DONE
DONE  out  1  one-cycle pulse at the end of a sequence
OVERRUN  out  1  sticky flag: U_WRT arrived while BUSY

Behaviour:
- Reset (RST_N=0 at a clock edge), from any state including mid-sequence, clears the following to 0:
  - jp, jm, dJ, gain and step registers; all internal U[i] shadows
  - MUL_REQ, U_WE, U_ADDR, U_DATA, BUSY, DONE, OVERRUN
- Reset loads lfsr = LFSR_SEED and returns the state to IDLE.
- JP_WRT/JM_WRT latch J_IN on the next edge in any state. A latch during BUSY does not disturb the running sequence, because dJ is already captured.
- States:
  - IDLE: on U_WRT, capture dJ = jp - jm (J_W+1 bits, sign-extended) and GAIN; set BUSY; go to MREQ.
  - MREQ: assert MUL_REQ with MUL_A=dJ, MUL_B=gain. MUL_REQ and both operands stay stable until MUL_ACK.
    - On MUL_ACK: capture step = MUL_P >>> GAIN_SHIFT; deassert MUL_REQ next cycle; go to UPD with i=0.
    - MUL_ACK in the same cycle as the request is legal (1-cycle multiply). MUL_ACK outside MREQ is ignored.
  - UPD: one channel per cycle. Compute new = sat(U[i] + (PERT_SIGN[i] ? step : -step)) with saturation to [-2^(U_W-1), 2^(U_W-1)-1].
    - Write U[i]=new; drive U_WE=1, U_ADDR=i, U_DATA=new, registered.
    - After i = N_CH-1 go to STEP.
  - STEP: advance the LFSR once (Fibonacci, taps 16,14,13,11, shift left, feedback into bit0); go to FIN.
  - FIN: DONE=1 for one cycle; clear BUSY; go to IDLE.
- Latency: U_WRT to the first U_WE = 2 + (ACK wait cycles) cycles. The U_WE burst is N_CH consecutive cycles with addresses 0..N_CH-1 ascending.
- Intermediate arithmetic is at least J_W+10 bits so that -step and the add never wrap before saturation. step = -2^(J_W+8) is negated without overflow.
- U_WRT while BUSY: ignored, OVERRUN=1 until reset. U_WRT in the same cycle as DONE is also an overrun.
- PERT_SIGN changes only in STEP and is stable throughout UPD.

Optional Feature:
SPGD_STEP_LIMIT_EN
- Defined: after the shift, step is clamped to [-STEP_MAX, STEP_MAX] before UPD.
- Undefined: no clamp; only output saturation applies. STEP_MAX is unused.

Test Plan:
1. Reset, then JP_WRT with J_IN=100, JM_WRT with J_IN=40, GAIN=16, U_WRT; MUL_ACK 1 cycle after MUL_REQ with MUL_P=960 -> eight U_WE pulses at addresses 0..7.
   - Seed low byte 0xE1: U_DATA = 60,-60,-60,-60,-60,60,60,60.
   - DONE pulses once; PERT_SIGN then equals the model's next LFSR value.
2. MUL_ACK delayed 5 cycles -> MUL_REQ, MUL_A=60 and MUL_B=16 held constant for all 5 cycles; no U_WE before ACK; first U_WE 2 cycles after ACK.
3. jp=32767, jm=-32768, GAIN=16, MUL_P=1048560 -> step=65535. Expected:
   - Without SPGD_STEP_LIMIT_EN: U_DATA saturates to 8191 on + channels and -8192 on - channels.
   - With SPGD_STEP_LIMIT_EN: values are ±1024.
4. Second U_WRT pulsed during UPD -> no extra sequence and exactly N_CH writes total; OVERRUN=1 and stays 1 until RST_N=0.
5. RST_N=0 for one cycle at channel 3 of UPD -> no further U_WE; all outputs 0 next cycle; PERT_SIGN=LFSR_SEED[7:0]; a fresh run from zeroed U reproduces scenario 1.
6. JP_WRT during MREQ with J_IN=500 -> current sequence still uses dJ=60; the next sequence uses jp=500.
